// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Multicycle signed multiply / divide unit. It takes operands
//               from the CPU A/B registers and holds results in HI/LO for
//               mfhi/mflo write-back. Multiply uses magnitude shift-add and
//               divide uses restoring shift-subtract, both followed by a
//               sign fixup.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     count;
  logic                 op_div;
  logic                 neg_a;
  logic                 neg_b;
  // Multiplicand for mult, divisor magnitude for div.
  logic [WIDTH-1:0]     opnd;
  // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0]   acc;

  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic                 div_zero_req;
  logic                 calc_last;
  logic                 finish_go;
  logic [WIDTH:0]       add_sum;
  logic [2*WIDTH-1:0]   mul_step;
  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH-1:0]   div_step;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  assign mag_a        = OpA[WIDTH-1] ? -OpA : OpA;
  assign mag_b        = OpB[WIDTH-1] ? -OpB : OpB;
  assign div_zero_req = Op && (OpB == '0);
  assign calc_last    = (count == CNT_W'(WIDTH - 1));
  // The divide-by-zero path parks one extra cycle in FINISH using the counter.
  assign finish_go    = (count == '0);

  // One multiply iteration: conditional add of the multiplicand, then shift right.
  assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
  assign mul_step = acc[0] ? {add_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

  // One restoring-divide iteration: shift in the next dividend bit, trial subtract.
  assign shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff     = shifted - {1'b0, opnd};
  assign div_step = diff[WIDTH] ? {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],    acc[WIDTH-2:0], 1'b1};

  // Sign fixup: product and quotient negate on differing signs, remainder follows dividend.
  assign prod_fix = (neg_a ^ neg_b) ? -acc : acc;
  assign quo_fix  = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign Busy = (state != S_IDLE);

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (Start) state_nxt = div_zero_req ? S_FINISH : S_CALC;
      S_CALC:   if (calc_last) state_nxt = S_FINISH;
      S_FINISH: if (finish_go) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count   <= '0;
      op_div  <= 1'b0;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      opnd    <= '0;
      acc     <= '0;
      DivZero <= 1'b0;
      Done    <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            op_div  <= Op;
            neg_a   <= OpA[WIDTH-1];
            neg_b   <= OpB[WIDTH-1];
            DivZero <= div_zero_req;
            opnd    <= Op ? mag_b : mag_a;
            if (div_zero_req) begin
              acc   <= {OpA, {WIDTH{1'b0}}};
              count <= CNT_W'(1);
            end else begin
              acc   <= {{WIDTH{1'b0}}, (Op ? mag_a : mag_b)};
              count <= '0;
            end
          end
        end
        S_CALC: begin
          acc   <= op_div ? div_step : mul_step;
          count <= calc_last ? '0 : count + CNT_W'(1);
        end
        S_FINISH: begin
          if (!finish_go) begin
            count <= count - CNT_W'(1);
          end else begin
            Done <= 1'b1;
            if (DivZero) begin
              Hi <= acc[2*WIDTH-1:WIDTH];
              Lo <= '1;
            end else if (op_div) begin
              Hi <= rem_fix;
              Lo <= quo_fix;
            end else begin
              Hi <= prod_fix[2*WIDTH-1:WIDTH];
              Lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit, comparing against a
//               plain-arithmetic signed multiply/divide reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic        Op = 1'b0;
  logic [31:0] OpA = '0;
  logic [31:0] OpB = '0;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int n_cmp = 0;
  int n_bad = 0;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: signed 64-bit product, or truncating signed division.
  function automatic void model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic dz, output int lat);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz  = 1'b0;
    lat = 33;
    if (!op) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi  = a;
      lo  = 32'hFFFF_FFFF;
      dz  = 1'b1;
      lat = 2;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  // Runs one operation starting from the current cycle; optional re-pulse of
  // Start with other operands at edge pulse_at while the unit is busy.
  task automatic run_op(input string tag, input logic op, input logic [31:0] a,
                        input logic [31:0] b, input int pulse_at,
                        input logic [31:0] pa, input logic [31:0] pb);
    logic [31:0] ehi, elo;
    logic        edz;
    int          elat;
    int          lat;
    model(op, a, b, ehi, elo, edz, elat);
    Start = 1'b1; Op = op; OpA = a; OpB = b;
    @(posedge Clk); #1;
    Start = 1'b0; Op = $urandom_range(1, 0); OpA = $urandom; OpB = $urandom;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      if (k == pulse_at) begin
        Start = 1'b1; Op = 1'b0; OpA = pa; OpB = pb;
      end
      @(posedge Clk); #1;
      Start = 1'b0;
      if (Done) begin
        lat = k;
        break;
      end
    end
    check_val({tag, " latency"}, 64'(lat), 64'(elat));
    check_val({tag, " hi"}, {32'd0, Hi}, {32'd0, ehi});
    check_val({tag, " lo"}, {32'd0, Lo}, {32'd0, elo});
    check_val({tag, " divzero"}, {63'd0, DivZero}, {63'd0, edz});
    check_val({tag, " busy"}, {63'd0, Busy}, 64'd0);
  endtask

  logic [31:0] ra, rb;
  logic        rop;
  logic [31:0] specials [6];
  logic [31:0] hold_hi, hold_lo;
  int          seen_done;

  initial begin
    specials[0] = 32'h8000_0000; specials[1] = 32'hFFFF_FFFF; specials[2] = 32'h7FFF_FFFF;
    specials[3] = 32'h0000_0001; specials[4] = 32'h0000_0000; specials[5] = 32'hFFFF_FFFE;

    // Reset state.
    repeat (2) @(negedge Clk);
    check_val("rst busy", {63'd0, Busy}, 64'd0);
    check_val("rst done", {63'd0, Done}, 64'd0);
    check_val("rst divzero", {63'd0, DivZero}, 64'd0);
    check_val("rst hi", {32'd0, Hi}, 64'd0);
    check_val("rst lo", {32'd0, Lo}, 64'd0);
    Reset = 1'b1;
    @(negedge Clk);

    // Directed cases, issued back-to-back so each new Start lands in the Done cycle.
    run_op("mul 11x3", 1'b0, 32'd11, 32'd3, 0, '0, '0);
    run_op("mul -2x3", 1'b0, 32'hFFFF_FFFE, 32'd3, 0, '0, '0);
    run_op("mul min^2", 1'b0, 32'h8000_0000, 32'h8000_0000, 0, '0, '0);
    run_op("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0, '0, '0);
    run_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0, '0, '0);
    run_op("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, '0, '0);
    run_op("div 5/0", 1'b1, 32'd5, 32'd0, 0, '0, '0);
    run_op("mul 2x2", 1'b0, 32'd2, 32'd2, 0, '0, '0);
    run_op("ignored start", 1'b0, 32'd11, 32'd3, 10, 32'd9, 32'd9);

    // Randomized operations, with boundary operands and zero divisors mixed in.
    for (int i = 0; i < 30; i++) begin
      rop = 1'($urandom_range(1, 0));
      ra  = ($urandom_range(3, 0) == 0) ? specials[$urandom_range(5, 0)] : $urandom;
      rb  = ($urandom_range(3, 0) == 0) ? specials[$urandom_range(5, 0)] : $urandom;
      if ($urandom_range(7, 0) == 0) rb = 32'd0;
      run_op($sformatf("rand%0d", i), rop, ra, rb, 0, '0, '0);
      if ($urandom_range(1, 0) == 1) @(negedge Clk);
    end

    // Hi/Lo must hold while idle.
    hold_hi = Hi; hold_lo = Lo;
    run_op("mul -5x7", 1'b0, 32'hFFFF_FFFB, 32'd7, 0, '0, '0);
    repeat (3) @(negedge Clk);
    check_val("idle hold lo", {32'd0, Lo}, 64'h0000_0000_FFFF_FFDD);

    // Reset in the middle of an operation aborts it.
    @(negedge Clk);
    Start = 1'b1; Op = 1'b0; OpA = 32'd11; OpB = 32'd3;
    @(posedge Clk); #1; Start = 1'b0;
    repeat (14) @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    check_val("abort busy", {63'd0, Busy}, 64'd0);
    check_val("abort hi", {32'd0, Hi}, 64'd0);
    check_val("abort lo", {32'd0, Lo}, 64'd0);
    @(negedge Clk);
    Reset = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (Done) seen_done++;
    end
    check_val("abort no done", 64'(seen_done), 64'd0);
    check_val("abort idle", {63'd0, Busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
